wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 we  input  1  GPR write enable from writeback stage.
REQ-005 waddr  input  5  GPR write address.
REQ-006 wdata  input  32  GPR write data.
REQ-007 whilo  input  1  HI/LO write enable from writeback stage.
REQ-008 hi_i  input  32  HI write data.
REQ-009 lo_i  input  32  LO write data.
REQ-010 re1  input  1  read port 1 enable.
REQ-011 raddr1  input  5  read port 1 address.
REQ-012 rdata1  output  32  read port 1 data, combinational.
REQ-013 re2  input  1  read port 2 enable.
REQ-014 raddr2  input  5  read port 2 address.
REQ-015 rdata2  output  32  read port 2 data, combinational.
REQ-016 hi_o  output  32  current HI value, bypassed.
REQ-017 lo_o  output  32  current LO value, bypassed.

Function
REQ-018 Storage SHALL be 32 x 32-bit GPRs plus one 32-bit HI and one 32-bit LO register.
REQ-019 On a rising edge with rst=0, we=1 and waddr!=0, the block SHALL write wdata to GPR[waddr].
REQ-020 Register 0 SHALL read as 32'h0 always; writes to address 0 SHALL be discarded.
REQ-021 On a rising edge with rst=0 and whilo=1, the block SHALL write hi_i to HI and lo_i to LO in the same edge.
REQ-022 Read latency SHALL be zero cycles: rdataN is a combinational function of raddrN, reN, stored state and the current write inputs.
REQ-023 Read priority per port, highest first: rst=1 -> 0; reN=0 -> 0; raddrN=0 -> 0; (we=1 and waddr==raddrN) -> wdata (write-through bypass); otherwise GPR[raddrN].
REQ-024 Both read ports SHALL operate independently; same address on both ports SHALL return identical data, including the bypass case.
REQ-025 hi_o/lo_o priority: rst=1 -> 0; whilo=1 -> hi_i/lo_i (bypass); otherwise stored HI/LO.
REQ-026 GPR write and HI/LO write in the same cycle SHALL both take effect; they do not interact.
REQ-027 Write enables with X-free but unchanged inputs over multiple cycles SHALL rewrite the same value with no side effect (idempotent).
REQ-028 The block SHALL contain no handshake; upstream stall/flush is expressed solely by we=0 and whilo=0.

Reset
REQ-029 On a rising edge with rst=1, all 32 GPRs, HI and LO SHALL be cleared to 32'h0.
REQ-030 While rst=1, any write request SHALL be ignored (reset wins over write in the same edge).
REQ-031 While rst=1, rdata1, rdata2, hi_o and lo_o SHALL be 32'h0 regardless of other inputs.
REQ-032 Reset asserted mid-operation SHALL discard all prior contents; the first cycle after rst deasserts SHALL read 0 from every address unless bypassed.

Verification
REQ-033 Reset then read all 32 addresses on both ports with re=1 -> every rdata = 32'h0, hi_o=lo_o=0.
REQ-034 Write waddr=5, wdata=32'hDEADBEEF, re1=1 raddr1=5 in same cycle -> rdata1=32'hDEADBEEF that cycle (bypass) and on the next cycle with we=0 (stored).
REQ-035 Write waddr=0, wdata=32'h12345678; read raddr1=raddr2=0 -> both 32'h0 in write cycle and after.
REQ-036 whilo=1, hi_i=32'hAAAA0001, lo_i=32'h5555FFFE -> same-cycle hi_o/lo_o show inputs; after edge with whilo=0 stored values persist.
REQ-037 Write GPR[7]=32'h1; next cycle rst=1 with we=1 waddr=7 wdata=32'h2 -> after edge GPR[7]=0, rdata=0 during rst.
REQ-038 re1=0, raddr1=7 (GPR[7]=32'h1), re2=1, raddr2=7 -> rdata1=0, rdata2=32'h1.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 GPR file plus HI/LO, two zero-latency read ports with
// write-through bypass from the writeback stage. Synchronous active-high reset.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        whilo,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // GPR storage: reset clears everything; address 0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        gpr[ADDR_W'(i)] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      gpr[waddr] <= wdata;
    end
  end

  // HI/LO storage, written together and independently of the GPR write
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (whilo) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Read port 1: reset/disable/r0 force zero, then same-cycle write bypass
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = gpr[raddr1];
      end
    end
  end

  // Read port 2: identical priority to port 1
  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = gpr[raddr2];
      end
    end
  end

  // HI/LO outputs with same-cycle bypass of the pending write
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      if (whilo) begin
        hi_o = hi_i;
        lo_o = lo_i;
      end else begin
        hi_o = hi_q;
        lo_o = lo_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table, reset sweep, and randomized cycles
// checked against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks;
  int errors;

  wb_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .whilo  (whilo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  // Reference model: architectural contents of the register file
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] wa,
                              input logic [31:0] wd, input logic wh,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic e1, input logic [4:0] a1,
                              input logic e2, input logic [4:0] a2,
                              input logic [31:0] x1, input logic [31:0] x2,
                              input logic [31:0] xh, input logic [31:0] xl);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.whilo = wh;
    v.hi_i = hi; v.lo_i = lo; v.re1 = e1; v.raddr1 = a1; v.re2 = e2; v.raddr2 = a2;
    v.exp_r1 = x1; v.exp_r2 = x2; v.exp_hi = xh; v.exp_lo = xl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
    whilo = v.whilo; hi_i = v.hi_i; lo_i = v.lo_i;
    re1 = v.re1; raddr1 = v.raddr1; re2 = v.re2; raddr2 = v.raddr2;
  endtask

  // Apply the architectural effect of the current inputs at a clock edge
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (we && waddr != 5'd0) m_gpr[waddr] = wdata;
      if (whilo) begin
        m_hi = hi_i;
        m_lo = lo_i;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic e, input logic [4:0] a);
    if (rst || !e || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return 32'h0;
    return whilo ? hi_i : m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return 32'h0;
    return whilo ? lo_i : m_lo;
  endfunction

  // Finish the current cycle: let the edge happen and keep the model in step
  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;

    vecs[0]  = mk(1,0,0,0,0,0,0, 1,3, 1,3, 0,0,0,0);
    vecs[1]  = mk(0,1,5,32'hDEADBEEF,0,0,0, 1,5, 1,5, 32'hDEADBEEF,32'hDEADBEEF,0,0);
    vecs[2]  = mk(0,0,5,0,0,0,0, 1,5, 1,6, 32'hDEADBEEF,0,0,0);
    vecs[3]  = mk(0,1,0,32'h12345678,0,0,0, 1,0, 1,0, 0,0,0,0);
    vecs[4]  = mk(0,0,0,0,0,0,0, 1,0, 1,0, 0,0,0,0);
    vecs[5]  = mk(0,0,0,0,1,32'hAAAA0001,32'h5555FFFE, 0,0, 0,0, 0,0,32'hAAAA0001,32'h5555FFFE);
    vecs[6]  = mk(0,0,0,0,0,32'h0000FFFF,32'h1, 0,0, 0,0, 0,0,32'hAAAA0001,32'h5555FFFE);
    vecs[7]  = mk(0,1,7,32'h1,1,32'h3,32'h4, 1,7, 1,7, 32'h1,32'h1,32'h3,32'h4);
    vecs[8]  = mk(1,1,7,32'h2,1,32'h9,32'h9, 1,7, 1,7, 0,0,0,0);
    vecs[9]  = mk(0,0,0,0,0,0,0, 1,5, 1,7, 0,0,0,0);
    vecs[10] = mk(0,1,7,32'h1,0,0,0, 0,7, 1,7, 0,32'h1,0,0);
    vecs[11] = mk(0,0,0,0,0,0,0, 0,7, 1,7, 0,32'h1,0,0);
    vecs[12] = mk(0,1,7,32'h1,0,0,0, 1,7, 0,7, 32'h1,0,0,0);
    vecs[13] = mk(0,1,7,32'h1,0,0,0, 1,7, 1,7, 32'h1,32'h1,0,0);
    vecs[14] = mk(0,1,9,32'h11,0,0,0, 1,9, 1,7, 32'h11,32'h1,0,0);
    vecs[15] = mk(0,0,0,0,0,0,0, 1,9, 1,7, 32'h11,32'h1,0,0);

    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    clock_edge();
    clock_edge();

    // Directed table: one record per cycle, checked before the edge
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d rdata1", i), rdata1, vecs[i].exp_r1);
      check($sformatf("vec%0d rdata2", i), rdata2, vecs[i].exp_r2);
      check($sformatf("vec%0d hi_o", i), hi_o, vecs[i].exp_hi);
      check($sformatf("vec%0d lo_o", i), lo_o, vecs[i].exp_lo);
      clock_edge();
    end

    // Populate a few registers, then reset and sweep every address
    for (int a = 1; a < 32; a += 3) begin
      drive(mk(0,1,5'(a),32'hC0DE0000 | 32'(a),1,32'(a),32'(a+1),0,0,0,0,0,0,0,0));
      clock_edge();
    end
    drive(mk(1,1,5'd4,32'hFFFFFFFF,1,32'h7,32'h8,1,4,1,4,0,0,0,0));
    @(negedge clk);
    check("rst rdata1", rdata1, 32'h0);
    check("rst hi_o", hi_o, 32'h0);
    clock_edge();
    for (int a = 0; a < 32; a++) begin
      drive(mk(0,0,0,0,0,0,0,1,5'(a),1,5'(31-a),0,0,0,0));
      @(negedge clk);
      check($sformatf("sweep r1 a%0d", a), rdata1, 32'h0);
      check($sformatf("sweep r2 a%0d", 31-a), rdata2, 32'h0);
      check($sformatf("sweep hi a%0d", a), hi_o, 32'h0);
      check($sformatf("sweep lo a%0d", a), lo_o, 32'h0);
      clock_edge();
    end

    // Randomized cycles against the reference model
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 29) == 0);
      we     = ($urandom_range(0, 2) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      whilo  = ($urandom_range(0, 3) == 0);
      hi_i   = $urandom;
      lo_i   = $urandom;
      re1    = ($urandom_range(0, 5) != 0);
      re2    = ($urandom_range(0, 5) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      @(negedge clk);
      check("rnd rdata1", rdata1, exp_rd(re1, raddr1));
      check("rnd rdata2", rdata2, exp_rd(re2, raddr2));
      check("rnd hi_o", hi_o, exp_hi());
      check("rnd lo_o", lo_o, exp_lo());
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
